// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/return bookkeeping, interrupt pending/enable,
// 64-bit cycle and retired-instruction counters, with RW/RS/RC access decode.
module csr_file #(
    parameter int              XLEN      = 32,
    parameter int              IRQ_NUM   = 16,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [11:0]        addr_i,
    input  logic [1:0]         op_i,
    input  logic [XLEN-1:0]    wdata_i,
    output logic [XLEN-1:0]    rdata_o,
    output logic               illegal_o,
    input  logic               trap_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    cause_i,
    input  logic               mret_i,
    input  logic               instret_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic               irq_req_o,
    output logic [XLEN-1:0]    irq_cause_o,
    output logic [XLEN-1:0]    trap_pc_o,
    output logic [XLEN-1:0]    mepc_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic               mst_mie;
    logic               mst_mpie;
    logic [IRQ_NUM-1:0] mie_q;
    logic [IRQ_NUM-1:0] mip_q;
    logic [XLEN-1:0]    mtvec_q;
    logic [XLEN-1:0]    mscratch_q;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;
    logic [63:0]        mcycle_q;
    logic [63:0]        minstret_q;

    logic               implemented;
    logic               wr_req;
    logic               we;
    logic [XLEN-1:0]    wval;
    logic [63:0]        mcycle_n;
    logic [63:0]        minstret_n;
    logic [IRQ_NUM-1:0] pend;
    logic [XLEN-1:0]    tvec_base;

    // Read mux; the high counter halves only exist on a 32-bit datapath.
    always_comb begin
        rdata_o     = '0;
        implemented = 1'b1;
        case (addr_i)
            A_MSTATUS: begin
                rdata_o[3] = mst_mie;
                rdata_o[7] = mst_mpie;
            end
            A_MIE:      rdata_o = XLEN'(mie_q);
            A_MTVEC:    rdata_o = mtvec_q;
            A_MSCRATCH: rdata_o = mscratch_q;
            A_MEPC:     rdata_o = mepc_q;
            A_MCAUSE:   rdata_o = mcause_q;
            A_MIP:      rdata_o = XLEN'(mip_q);
            A_MCYCLE:   rdata_o = mcycle_q[XLEN-1:0];
            A_MINSTRET: rdata_o = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                implemented = (XLEN == 32);
                if (XLEN == 32) rdata_o = XLEN'(mcycle_q[63:32]);
            end
            A_MINSTRETH: begin
                implemented = (XLEN == 32);
                if (XLEN == 32) rdata_o = XLEN'(minstret_q[63:32]);
            end
            A_MHARTID:  rdata_o = '0;
            default:    implemented = 1'b0;
        endcase
    end

    // Set/clear with an all-zero mask is a pure read: no write, no fault.
    always_comb begin
        wr_req    = (op_i == OP_RW) || ((op_i != OP_NONE) && (wdata_i != '0));
        illegal_o = (op_i != OP_NONE) &&
                    (!implemented || (wr_req && (addr_i == A_MIP || addr_i == A_MHARTID)));
        we        = wr_req && !illegal_o;
        case (op_i)
            OP_RW:   wval = wdata_i;
            OP_RS:   wval = rdata_o | wdata_i;
            OP_RC:   wval = rdata_o & ~wdata_i;
            default: wval = rdata_o;
        endcase
    end

    // A half written by software replaces only that half of the incremented count.
    always_comb begin
        mcycle_n   = mcycle_q + 64'd1;
        minstret_n = minstret_q + 64'(instret_i);
        if (we && addr_i == A_MCYCLE) begin
            if (XLEN == 32) mcycle_n[31:0] = wval[31:0];
            else            mcycle_n = 64'(wval);
        end
        if (we && addr_i == A_MINSTRET) begin
            if (XLEN == 32) minstret_n[31:0] = wval[31:0];
            else            minstret_n = 64'(wval);
        end
        if (XLEN == 32 && we && addr_i == A_MCYCLEH)   mcycle_n[63:32]   = wval[31:0];
        if (XLEN == 32 && we && addr_i == A_MINSTRETH) minstret_n[63:32] = wval[31:0];
    end

    assign pend      = mip_q & mie_q;
    assign irq_req_o = mst_mie & (|pend);

    always_comb begin
        irq_cause_o = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[i]) irq_cause_o = XLEN'(i);
        end
        if (|pend) irq_cause_o[XLEN-1] = 1'b1;
    end

    assign tvec_base = mtvec_q & ~XLEN'(3);
    assign trap_pc_o = (mtvec_q[0] && cause_i[XLEN-1]) ?
                       tvec_base + {cause_i[XLEN-3:0], 2'b00} : tvec_base;
    assign mepc_o    = mepc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mip_q      <= irq_i;
            mcycle_q   <= mcycle_n;
            minstret_q <= minstret_n;
            if (we) begin
                case (addr_i)
                    A_MIE:      mie_q      <= wval[IRQ_NUM-1:0];
                    A_MTVEC:    mtvec_q    <= wval & ~XLEN'(2);
                    A_MSCRATCH: mscratch_q <= wval;
                    default: ;
                endcase
            end
            // Trap entry wins over return and over software writes to trap state.
            if (trap_i) begin
                mepc_q   <= pc_i & ~XLEN'(3);
                mcause_q <= cause_i;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else begin
                if (we && addr_i == A_MEPC)   mepc_q   <= wval & ~XLEN'(3);
                if (we && addr_i == A_MCAUSE) mcause_q <= wval;
                if (mret_i) begin
                    mst_mie  <= mst_mpie;
                    mst_mpie <= 1'b1;
                end else if (we && addr_i == A_MSTATUS) begin
                    mst_mie  <= wval[3];
                    mst_mpie <= wval[7];
                end
            end
        end
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every CSR and data port (32 or 64).
REQ-002 SHALL have parameter IRQ_NUM, default 16, number of interrupt inputs (1..XLEN-1).
REQ-003 SHALL have parameter MTVEC_RST, default 0, reset value of mtvec.
REQ-004 SHALL have ports: clk_i  in  1  clock, rising edge.
REQ-005 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: addr_i  in  12  CSR address.
REQ-007 SHALL have ports: op_i  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-008 SHALL have ports: wdata_i  in  XLEN  write or mask operand.
REQ-009 SHALL have ports: rdata_o  out  XLEN  current CSR value, combinational.
REQ-010 SHALL have ports: illegal_o  out  1  access fault, combinational.
REQ-011 SHALL have ports: trap_i  in  1  trap entry strobe; pc_i  in  XLEN  PC of trapping instruction; cause_i  in  XLEN  trap cause.
REQ-012 SHALL have ports: mret_i  in  1  return strobe; instret_i  in  1  instruction retired.
REQ-013 SHALL have ports: irq_i  in  IRQ_NUM  level interrupt lines.
REQ-014 SHALL have ports: irq_req_o  out  1; irq_cause_o  out  XLEN; trap_pc_o  out  XLEN; mepc_o  out  XLEN.

Function
REQ-015 SHALL implement mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02; for XLEN=32 also mcycleh 0xB80, minstreth 0xB82 (upper halves).
REQ-016 SHALL expose mhartid 0xF14 read-only as 0 and mip as read-only.
REQ-017 SHALL compute next value: RW = wdata_i; RS = old | wdata_i; RC = old & ~wdata_i; write committed at next rising edge.
REQ-018 SHALL suppress the write for RS/RC with wdata_i == 0 (no side effects, not illegal).
REQ-019 SHALL assert illegal_o when op_i != 00 and addr_i is unimplemented, or a write (per REQ-018) targets mip/mhartid; no state changes on illegal access; rdata_o = 0 for unimplemented addresses.
REQ-020 SHALL mask writable bits: mie bits above IRQ_NUM-1 read 0; mepc bits [1:0] read 0; mtvec bit 1 reads 0.
REQ-021 SHALL register irq_i into mip[IRQ_NUM-1:0] every cycle (1-cycle latency).
REQ-022 SHALL drive irq_req_o = mstatus.MIE & |(mip & mie), combinational.
REQ-023 SHALL drive irq_cause_o = MSB set, low bits = index of lowest set bit of (mip & mie); 0 when none.
REQ-024 On trap_i: mepc <= pc_i & ~3, mcause <= cause_i, MPIE <= MIE, MIE <= 0, all at the same edge.
REQ-025 SHALL drive trap_pc_o = mtvec base ({mtvec[XLEN-1:2],2'b00}) + 4*cause_i[XLEN-2:0] when mtvec[0]=1 and cause_i MSB=1, else base.
REQ-026 On mret_i: MIE <= MPIE, MPIE <= 1.
REQ-027 SHALL give trap_i priority over mret_i and over any same-cycle CSR write to mstatus/mepc/mcause; writes to other CSRs in that cycle still commit.
REQ-028 SHALL give mret_i priority over a same-cycle CSR write to mstatus.
REQ-029 SHALL increment the 64-bit mcycle every cycle and the 64-bit minstret when instret_i=1, wrapping 2^64-1 -> 0.
REQ-030 A CSR write to any counter half SHALL override that half's increment in that cycle; the other half keeps its incremented value, including carry.
REQ-031 SHALL drive mepc_o = mepc continuously.

Reset
REQ-032 While rst_i=1: mtvec = MTVEC_RST; all other CSRs, mip and counters = 0; irq_req_o = 0.
REQ-033 Reset assertion mid-trap or mid-write SHALL discard the pending update; first update after release occurs on the first rising edge with rst_i=0.

Verification
REQ-034 Reset, read all 12 addresses -> mtvec=MTVEC_RST, others 0, illegal_o=0.
REQ-035 RW mie=0xFFFFFFFF, RS mie 0, RC mie 0x1 -> reads 0x0000FFFF, 0x0000FFFF, 0x0000FFFE; RW 0x7C0 -> illegal_o=1, no change.
REQ-036 mstatus.MIE=1, mie=0x8, irq_i=0x8 -> irq_req_o=1 after 1 cycle, irq_cause_o=0x80000003; mtvec=0x101 -> trap_pc_o=0x10C.
REQ-037 trap_i with pc_i=0x1236, cause_i=0x80000003 plus RW mepc=0x55 same cycle -> mepc=0x1234, mcause=0x80000003, MIE=0, MPIE=1; mret_i -> MIE=1, MPIE=1.
REQ-038 Write mcycle=0xFFFFFFFF, mcycleh=0 (XLEN=32) -> next cycle mcycle=0, mcycleh=1; instret_i held 5 cycles -> minstret +5.
